// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - operation codes presented on muldiv_unit.op
//   - FSM state encoding
//   - iteration-counter width helper ($clog2(width)+1)
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam int MDU_WIDTH = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W = $clog2(MDU_WIDTH) + 1;

endpackage

// File: rtl/flopenr.sv
// flopenr: WIDTH-wide register with enable and asynchronous active-high reset.
//   clk   : clock, rising edge
//   reset : asynchronous clear to zero
//   en    : load enable
//   d     : next value
//   q     : registered value
module flopenr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the architectural HI/LO
// registers. A MULT/MULTU/DIV/DIVU request accepted in idle runs WIDTH
// radix-2 iterations on unsigned magnitudes followed by one sign-fixup cycle,
// so HI/LO update 33 cycles after the start edge (WIDTH=32). MTHI/MTLO write
// HI/LO directly from operand a in a single cycle.
//   clk   : clock, rising edge
//   reset : asynchronous active-high clear of all state
//   start : one-cycle request, sampled only while idle
//   op    : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   a, b  : operands (dividend / divisor for divides)
//   busy  : high while a MULT/DIV is in flight
//   done  : one-cycle pulse after HI/LO are written by MULT/DIV
//   hi,lo : HI/LO registers (product high/low, remainder/quotient)
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    // Two's-complement negate when neg is set; used both to take magnitudes
    // on entry and to restore signs on exit.
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic signed [WIDTH-1:0] v,
                                                    input logic neg);
        logic signed [WIDTH-1:0] r;
        r = neg ? -v : v;
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic signed [2*WIDTH-1:0] v,
                                                       input logic neg);
        logic signed [2*WIDTH-1:0] r;
        r = neg ? -v : v;
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // product, or {unused, dividend/quotient}
    logic [WIDTH:0]     rem_q, rem_d;     // restoring-divide partial remainder
    logic [WIDTH-1:0]   mcand_q, mcand_d; // |b|: multiplicand or divisor
    logic               sa_q, sa_d;       // sign of a (signed ops only)
    logic               sb_q, sb_d;       // sign of b (signed ops only)
    logic               is_div_q, is_div_d;
    logic               done_q, done_d;

    logic               signed_op;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH+1:0]   div_trial;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    logic               hi_en, lo_en;
    logic [WIDTH-1:0]   hi_d, lo_d;

    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift right keeping the carry.
    // Divide step: shift the next dividend bit into the remainder and keep the
    // difference only if it did not go negative.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_trial = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_trial - {2'b00, mcand_q};
        div_ok    = ~div_diff[WIDTH+1];
        prod_fix  = cond_neg_2w(acc_q, sa_q ^ sb_q);
        quot_fix  = cond_neg_w(acc_q[WIDTH-1:0], sa_q ^ sb_q);
        rem_fix   = cond_neg_w(rem_q[WIDTH-1:0], sa_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        mcand_d   = mcand_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        is_div_d  = is_div_q;
        done_d    = 1'b0;
        signed_op = 1'b0;
        hi_en     = 1'b0;
        lo_en     = 1'b0;
        hi_d      = hi;
        lo_d      = lo;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU) begin
                        signed_op = (op == OP_MULT) || (op == OP_DIV);
                        sa_d      = signed_op & a[WIDTH-1];
                        sb_d      = signed_op & b[WIDTH-1];
                        acc_d     = {{WIDTH{1'b0}}, cond_neg_w(a, sa_d)};
                        mcand_d   = cond_neg_w(b, sb_d);
                        rem_d     = '0;
                        cnt_d     = '0;
                        is_div_d  = (op == OP_DIV) || (op == OP_DIVU);
                        state_d   = S_CALC;
                    end else if (op == OP_MTHI) begin
                        hi_en = 1'b1;
                        hi_d  = a;
                    end else if (op == OP_MTLO) begin
                        lo_en = 1'b1;
                        lo_d  = a;
                    end
                end
            end

            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    rem_d = div_ok ? div_diff[WIDTH:0] : div_trial[WIDTH:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
                end else begin
                    acc_d = mul_next;
                end
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end

            S_FIX: begin
                hi_en   = 1'b1;
                lo_en   = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (mcand_q == '0) begin
                    // Divide by zero: the remainder register ends holding |a|,
                    // and the dividend sign fixup turns that back into raw a.
                    lo_d = '1;
                    hi_d = rem_fix;
                end else begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            mcand_q  <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_div_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            mcand_q  <= mcand_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            is_div_q <= is_div_d;
            done_q   <= done_d;
        end
    end

    flopenr #(.WIDTH(WIDTH)) u_hi (
        .clk   (clk),
        .reset (reset),
        .en    (hi_en),
        .d     (hi_d),
        .q     (hi)
    );

    flopenr #(.WIDTH(WIDTH)) u_lo (
        .clk   (clk),
        .reset (reset),
        .en    (lo_en),
        .d     (lo_d),
        .q     (lo)
    );

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam logic [2:0] T_MULT  = 3'b000;
    localparam logic [2:0] T_MULTU = 3'b001;
    localparam logic [2:0] T_DIV   = 3'b010;
    localparam logic [2:0] T_DIVU  = 3'b011;
    localparam logic [2:0] T_MTHI  = 3'b100;
    localparam logic [2:0] T_MTLO  = 3'b101;
    localparam logic [2:0] T_NOP   = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
    task automatic model_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (o)
            T_MULT: begin
                p = 64'(sa * sb);
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            T_MULTU: begin
                p = {32'h0, av} * {32'h0, bv};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            T_DIV: begin
                if (bv == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = av; end
                else begin
                    sq = sa / sb; sr = sa % sb;
                    m_lo = 32'(sq); m_hi = 32'(sr);
                end
            end
            T_DIVU: begin
                if (bv == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = av; end
                else begin m_lo = av / bv; m_hi = av % bv; end
            end
            T_MTHI: m_hi = av;
            T_MTLO: m_lo = av;
            default: ;
        endcase
    endtask

    // Issues one MULT/DIV op and follows it to its done pulse. Optionally drives
    // a second request at sample inj_k while the first is in flight.
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input int inj_k, input logic [2:0] inj_op,
                          output int lat, output int busy_n, output int hold_bad);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo; lat = -1; busy_n = 0; hold_bad = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; op = T_NOP; a = $urandom; b = $urandom;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (done) begin lat = k; break; end
            if (busy) busy_n++;
            if (hi !== h0 || lo !== l0) hold_bad++;
            if (k == inj_k) begin
                start = 1'b1; op = inj_op; a = $urandom; b = $urandom;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] av,
                            input logic [31:0] bv, input int inj_k, input logic [2:0] inj_op);
        int lat, busy_n, hold_bad;
        run_op(o, av, bv, inj_k, inj_op, lat, busy_n, hold_bad);
        model_op(o, av, bv);
        n_tests++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL %s latency: got %0d want 33", name, lat);
        end
        n_tests++;
        if (hi !== m_hi) begin
            n_fail++; $display("FAIL %s hi: got %08h want %08h (a=%08h b=%08h op=%0d)", name, hi, m_hi, av, bv, o);
        end
        n_tests++;
        if (lo !== m_lo) begin
            n_fail++; $display("FAIL %s lo: got %08h want %08h (a=%08h b=%08h op=%0d)", name, lo, m_lo, av, bv, o);
        end
        n_tests++;
        if (busy_n !== 33 || hold_bad !== 0) begin
            n_fail++; $display("FAIL %s busy/hold: busy cycles %0d want 33, hi/lo changes during calc %0d want 0", name, busy_n, hold_bad);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("FAIL reset_state: busy=%b done=%b hi=%08h lo=%08h want 0/0/0/0", busy, done, hi, lo);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_directed;
        check_op("multu_max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, T_NOP);
        n_tests++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || busy !== 1'b0) begin
            n_fail++; $display("FAIL multu_max_const: hi=%08h lo=%08h busy=%b want fffffffe/00000001/0", hi, lo, busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL done_pulse_width: done=%b want 0 one cycle later", done);
        end
        check_op("mult_neg", T_MULT, 32'hFFFF_FFFD, 32'd7, -1, T_NOP);
        n_tests++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            n_fail++; $display("FAIL mult_neg_const: hi=%08h lo=%08h want ffffffff/ffffffeb", hi, lo);
        end
        check_op("div_neg", T_DIV, 32'hFFFF_FFF9, 32'd2, -1, T_NOP);
        n_tests++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++; $display("FAIL div_neg_const: hi=%08h lo=%08h want ffffffff/fffffffd", hi, lo);
        end
        check_op("divu", T_DIVU, 32'd100, 32'd7, -1, T_NOP);
        check_op("divu_zero", T_DIVU, 32'd100, 32'd0, -1, T_NOP);
        n_tests++;
        if (hi !== 32'h0000_0064 || lo !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL divu_zero_const: hi=%08h lo=%08h want 00000064/ffffffff", hi, lo);
        end
        check_op("div_zero_neg", T_DIV, 32'hFFFF_FF00, 32'd0, -1, T_NOP);
        check_op("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, T_NOP);
        n_tests++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            n_fail++; $display("FAIL div_ovf_const: hi=%08h lo=%08h want 00000000/80000000", hi, lo);
        end
        check_op("mult_minmin", T_MULT, 32'h8000_0000, 32'h8000_0000, -1, T_NOP);
        check_op("div_rem_sign", T_DIV, 32'd7, 32'hFFFF_FFFE, -1, T_NOP);
    endtask

    task automatic test_mt;
        logic [31:0] h0, l0;
        @(negedge clk);
        start = 1'b1; op = T_MTHI; a = 32'h1234; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0; op = T_NOP;
        model_op(T_MTHI, 32'h1234, 32'h0);
        n_tests++;
        if (hi !== 32'h1234 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mthi: hi=%08h busy=%b done=%b want 00001234/0/0", hi, busy, done);
        end
        @(negedge clk);
        start = 1'b1; op = T_MTLO; a = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0; op = T_NOP;
        model_op(T_MTLO, 32'h5678, 32'h0);
        n_tests++;
        if (lo !== 32'h5678 || hi !== 32'h1234 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mtlo: hi=%08h lo=%08h busy=%b done=%b want 00001234/00005678/0/0", hi, lo, busy, done);
        end
        h0 = hi; l0 = lo;
        @(negedge clk);
        start = 1'b1; op = 3'b110; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0; op = T_NOP;
        @(posedge clk); #1;
        n_tests++;
        if (hi !== h0 || lo !== l0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL op_11x: hi=%08h lo=%08h busy=%b done=%b want %08h/%08h/0/0", hi, lo, busy, done, h0, l0);
        end
    endtask

    task automatic test_ignored;
        check_op("mtlo_mid_div", T_DIV, 32'd1000, 32'd7, 12, T_MTLO);
        check_op("mthi_mid_mul", T_MULTU, 32'hDEAD_BEEF, 32'd3, 20, T_MTHI);
        check_op("mult_mid_div", T_DIVU, 32'hFFFF_0000, 32'd13, 5, T_MULT);
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL ignored_no_restart: busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        // run_op drives the next start during the done cycle.
        check_op("b2b_first", T_MULT, 32'hFFFF_FF85, 32'd1000, -1, T_NOP);
        check_op("b2b_second", T_DIV, 32'hFFFF_FC18, 32'd33, -1, T_NOP);
        check_op("b2b_third", T_DIVU, 32'd5, 32'd9, -1, T_NOP);
    endtask

    task automatic test_reset_mid;
        int done_seen;
        @(negedge clk);
        start = 1'b1; op = T_MTHI; a = 32'hAAAA_5555;
        @(negedge clk);
        op = T_MTLO; a = 32'h1357_9BDF;
        @(negedge clk);
        op = T_MULTU; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; op = T_NOP;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid: busy=%b done=%b hi=%08h lo=%08h want 0/0/0/0", busy, done, hi, lo);
        end
        @(negedge clk); reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy || hi !== 32'h0 || lo !== 32'h0) done_seen++;
        end
        n_tests++;
        if (done_seen !== 0) begin
            n_fail++; $display("FAIL reset_mid_quiet: cycles with activity after abort %0d want 0", done_seen);
        end
        check_op("after_reset", T_MULTU, 32'd5, 32'd6, -1, T_NOP);
        n_tests++;
        if (lo !== 32'd30 || hi !== 32'd0) begin
            n_fail++; $display("FAIL after_reset_const: hi=%08h lo=%08h want 00000000/0000001e", hi, lo);
        end
    endtask

    function automatic logic [31:0] pick_val();
        int s;
        s = $urandom_range(0, 7);
        case (s)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 50));
            4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] av, bv;
        for (int i = 0; i < 40; i++) begin
            o  = 3'($urandom_range(0, 3));
            av = pick_val();
            bv = pick_val();
            check_op($sformatf("rand%0d", i), o, av, bv, -1, T_NOP);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mt();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of the register file: takes rd1/rd2 as operands on a start pulse and computes over 33 cycles.
- Holds results in HI/LO, which feed the mfhi/mflo write-back mux.
- Replaces a combinational 64-bit multiplier/divider, which the single-cycle path cannot afford.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  single-cycle request; sampled on a rising edge while idle.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- a  input  WIDTH  operand A (rs / rd1); dividend for divides.
- b  input  WIDTH  operand B (rt / rd2); divisor for divides.
- busy  output  1  high while a MULT/DIV operation is in progress.
- done  output  1  one-cycle pulse when HI/LO have been updated by MULT/DIV.
- hi  output  WIDTH  HI register (product high / remainder).
- lo  output  WIDTH  LO register (product low / quotient).

Behaviour:
- Clock and reset: clock clk; reset is asynchronous, active-high.
- Reset values: busy=0, done=0, hi=0, lo=0, FSM=IDLE, iteration counter=0, operand latches=0.
- FSM states and transitions:
  - IDLE -> CALC on start with op in {MULT, MULTU, DIV, DIVU}.
  - CALC -> FIX after WIDTH iterations.
  - FIX -> IDLE unconditionally.
- Start edge E0 (start=1 in IDLE, MULT/DIV op):
  - Latch a, b and op. For signed ops latch magnitudes plus the sign bits of a and b.
  - Enter CALC; busy=1 from the cycle after E0.
  - a and b may change freely after E0.
- CALC, edges E1..E32:
  - Multiply: one radix-2 shift-add step per edge on a 2*WIDTH accumulator.
  - Divide: one restoring shift-subtract step per edge; the remainder register is WIDTH+1 bits.
- FIX, edge E33:
  - Apply sign fixup, write hi/lo, set done=1 and busy=0 for the cycle after E33.
  - done then returns to 0.
  - Total latency: results visible 33 cycles after the start edge.
- Sign rules:
  - Product is negated (two's complement, 2*WIDTH bits) when sign(a) != sign(b).
  - Quotient is negated when sign(a) != sign(b).
  - Remainder takes the sign of the dividend.
  - Unsigned ops apply no fixup.
- Result placement:
  - MULT/MULTU: hi = product[2W-1:W], lo = product[W-1:0].
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero (b == 0, DIV or DIVU): same 33-cycle latency; lo = all ones, hi = a as latched (raw, no sign fixup); done pulses normally.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. Wraps, no exception.
- MTHI/MTLO:
  - Accepted only in IDLE; on the start edge, hi <= a (MTHI) or lo <= a (MTLO).
  - No busy, no done; the new value is visible the next cycle.
- Ignored requests:
  - start while busy (any op, including MTHI/MTLO): ignored, in-flight operation unaffected.
  - Ops 11x: ignored, no state change.
- Read access: hi/lo are registered outputs and always reflect the last committed value. During CALC they keep their old values; intermediate accumulator state is never exposed.
- Reset mid-operation: immediate abort to the reset state; no done pulse; hi/lo = 0.
- Back-to-back: start asserted in the done cycle (state IDLE) is accepted.

Decomposition:
- Shared package mdu_pkg holds:
  - op codes: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO;
  - the FSM state enum: S_IDLE, S_CALC, S_FIX;
  - the counter width constant, $clog2(WIDTH)+1.
- hi and lo use the existing flopenr register (WIDTH-wide, async reset, enable).
- The datapath and FSM stay in a single module; no further sub-module is needed.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles, done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 while idle -> hi=0x1234 next cycle, no busy or done; MTLO a=0x5678 issued mid-DIV -> ignored, final lo is the quotient.
- Start MULTU 5*6, assert reset at cycle 10 -> busy=0, hi=lo=0, no done; a new MULTU 5*6 after reset -> lo=30, hi=0.
